// File: rtl/quad_decoder.sv
// -----------------------------------------------------------------------------
// quad_decoder
//   Quadrature encoder decoder with sub-step (detent) accumulation and a
//   wrapping or saturating position counter.
//
//   Parameters
//     WIDTH   : position counter width in bits
//     DETENT  : quarter-steps per reported step (1, 2 or 4)
//     WRAP    : 1 = position wraps modulo 2^WIDTH, 0 = position saturates
//     MAX_POS : upper saturation limit (only meaningful when WRAP = 0)
//
//   Ports
//     clk      : clock, all state changes on the rising edge
//     rst_n    : asynchronous active-low reset
//     a_in     : encoder channel A level (already debounced, clk-synchronous)
//     b_in     : encoder channel B level (already debounced, clk-synchronous)
//     clr      : synchronous clear of position and sub-step accumulator
//     position : current unsigned position
//     step     : one-cycle pulse in the cycle position changes
//     dir      : direction of the most recent step (1 = forward)
//     err      : one-cycle pulse on a double AB transition
// -----------------------------------------------------------------------------
module quad_decoder #(
  parameter int               WIDTH   = 8,
  parameter int               DETENT  = 4,
  parameter int               WRAP    = 1,
  parameter logic [WIDTH-1:0] MAX_POS = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clr,
  output logic [WIDTH-1:0] position,
  output logic             step,
  output logic             dir,
  output logic             err
);

  typedef enum logic {ST_INIT, ST_TRACK} state_t;

  // Four signed bits cover the transient +/-DETENT value for DETENT <= 4.
  localparam logic signed [3:0] DET_P = 4'(DETENT);
  localparam logic signed [3:0] DET_N = -DET_P;

  state_t            state_q, state_d;
  logic [1:0]        ab_cur_q, ab_cur_d;
  logic [1:0]        ab_prev_q, ab_prev_d;
  logic signed [3:0] sub_q, sub_d;
  logic [WIDTH-1:0]  position_q, position_d;
  logic              step_q, step_d;
  logic              dir_q, dir_d;
  logic              err_q, err_d;

  logic              quarter_fwd, quarter_rev, quarter_dbl;
  logic              step_fwd, step_rev;
  logic signed [3:0] sub_inc, sub_dec;

  always_comb begin
    state_d   = ST_TRACK;
    ab_cur_d  = {a_in, b_in};
    // While in INIT, ab_prev takes the level ab_cur is capturing this edge,
    // so the first comparison in TRACK is against the live level and a
    // non-00 AB at reset release decodes as "no change".
    ab_prev_d = (state_q == ST_INIT) ? ab_cur_d : ab_cur_q;

    quarter_fwd = 1'b0;
    quarter_rev = 1'b0;
    quarter_dbl = 1'b0;
    if (state_q == ST_TRACK) begin
      case ({ab_prev_q, ab_cur_q})
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: quarter_fwd = 1'b1;
        4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: quarter_rev = 1'b1;
        4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: quarter_dbl = 1'b1;
        default: ;
      endcase
    end

    sub_inc  = sub_q + 4'sd1;
    sub_dec  = sub_q - 4'sd1;
    sub_d    = sub_q;
    step_fwd = 1'b0;
    step_rev = 1'b0;
    if (quarter_fwd) begin
      if (sub_inc == DET_P) begin
        sub_d    = 4'sd0;
        step_fwd = 1'b1;
      end else begin
        sub_d = sub_inc;
      end
    end else if (quarter_rev) begin
      if (sub_dec == DET_N) begin
        sub_d    = 4'sd0;
        step_rev = 1'b1;
      end else begin
        sub_d = sub_dec;
      end
    end

    position_d = position_q;
    step_d     = 1'b0;
    dir_d      = dir_q;
    err_d      = quarter_dbl;

    // dir follows every issued step, even one blocked by saturation.
    if (step_fwd) begin
      dir_d = 1'b1;
      if ((WRAP != 0) || (position_q != MAX_POS)) begin
        position_d = position_q + WIDTH'(1);
        step_d     = 1'b1;
      end
    end
    if (step_rev) begin
      dir_d = 1'b0;
      if ((WRAP != 0) || (position_q != '0)) begin
        position_d = position_q - WIDTH'(1);
        step_d     = 1'b1;
      end
    end

    // Clear wins over a simultaneous step; err, dir and AB tracking continue.
    if (clr) begin
      position_d = '0;
      sub_d      = 4'sd0;
      step_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      ab_cur_q   <= 2'b00;
      ab_prev_q  <= 2'b00;
      sub_q      <= 4'sd0;
      position_q <= '0;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ab_cur_q   <= ab_cur_d;
      ab_prev_q  <= ab_prev_d;
      sub_q      <= sub_d;
      position_q <= position_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      err_q      <= err_d;
    end
  end

  assign position = position_q;
  assign step     = step_q;
  assign dir      = dir_q;
  assign err      = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// -----------------------------------------------------------------------------
// tb_quad_decoder
//   Three decoder instances share one stimulus stream:
//     inst 0 (w): WIDTH 8, DETENT 4, wrapping
//     inst 1 (s): WIDTH 8, DETENT 4, saturating at 6
//     inst 2 (n): WIDTH 4, DETENT 2, wrapping
//   Directed scenarios check fixed expected values; the random scenario
//   checks every cycle against a phase-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_quad_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_in = 1'b0;
  logic b_in = 1'b0;
  logic clr = 1'b0;

  logic [7:0] pos_w, pos_s;
  logic [3:0] pos_n;
  logic step_w, dir_w, err_w;
  logic step_s, dir_s, err_s;
  logic step_n, dir_n, err_n;

  always #5 clk = ~clk;

  quad_decoder #(.WIDTH(8), .DETENT(4), .WRAP(1)) dut_w (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .clr(clr),
    .position(pos_w), .step(step_w), .dir(dir_w), .err(err_w));

  quad_decoder #(.WIDTH(8), .DETENT(4), .WRAP(0), .MAX_POS(8'd6)) dut_s (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .clr(clr),
    .position(pos_s), .step(step_s), .dir(dir_s), .err(err_s));

  quad_decoder #(.WIDTH(4), .DETENT(2), .WRAP(1)) dut_n (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .clr(clr),
    .position(pos_n), .step(step_n), .dir(dir_n), .err(err_n));

  logic [7:0] pos_arr [3];
  logic [2:0] step_arr, dir_arr, err_arr;
  assign pos_arr[0] = pos_w;
  assign pos_arr[1] = pos_s;
  assign pos_arr[2] = {4'b0000, pos_n};
  assign step_arr = {step_n, step_s, step_w};
  assign dir_arr  = {dir_n, dir_s, dir_w};
  assign err_arr  = {err_n, err_s, err_w};

  // ---------------- reference model ----------------
  localparam int P_DET  [3] = '{4, 4, 2};
  localparam int P_WRAP [3] = '{1, 0, 1};
  localparam int P_MAX  [3] = '{255, 6, 15};
  localparam int P_MOD  [3] = '{256, 256, 16};

  typedef struct packed {
    int   pos;
    int   sub;
    logic step;
    logic dir;
    logic err;
  } mst_t;

  mst_t       m [3];
  logic [1:0] h_old, h_new;   // last two AB samples taken since reset
  int         age;            // number of samples taken since reset (max 2)

  // Gray phase index around the forward rotation 00 -> 10 -> 11 -> 01.
  function automatic int ph_of(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] ab_of(input int ph);
    case (ph)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  // 0 = no move, 1 = forward quarter, 3 = reverse quarter, 2 = double change
  function automatic int delta(input logic [1:0] from, input logic [1:0] to);
    return (ph_of(to) - ph_of(from) + 4) % 4;
  endfunction

  function automatic mst_t next_state(input int i, input int d, input logic c, input mst_t s);
    mst_t r;
    int   go;
    r = s;
    go = 0;
    r.step = 1'b0;
    r.err = 1'b0;
    if (d == 2) begin
      r.err = 1'b1;
    end else if (d == 1) begin
      r.sub = s.sub + 1;
      if (r.sub == P_DET[i]) begin r.sub = 0; go = 1; end
    end else if (d == 3) begin
      r.sub = s.sub - 1;
      if (r.sub == -P_DET[i]) begin r.sub = 0; go = -1; end
    end
    if (go == 1) begin
      r.dir = 1'b1;
      if (P_WRAP[i] != 0) begin r.pos = (s.pos + 1) % P_MOD[i]; r.step = 1'b1; end
      else if (s.pos < P_MAX[i]) begin r.pos = s.pos + 1; r.step = 1'b1; end
    end
    if (go == -1) begin
      r.dir = 1'b0;
      if (P_WRAP[i] != 0) begin r.pos = (s.pos + P_MOD[i] - 1) % P_MOD[i]; r.step = 1'b1; end
      else if (s.pos > 0) begin r.pos = s.pos - 1; r.step = 1'b1; end
    end
    if (c) begin
      r.pos = 0;
      r.sub = 0;
      r.step = 1'b0;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) m[i] <= '0;
      h_old <= 2'b00;
      h_new <= 2'b00;
      age   <= 0;
    end else begin
      for (int i = 0; i < 3; i++)
        m[i] <= next_state(i, (age >= 2) ? delta(h_old, h_new) : 0, clr, m[i]);
      h_old <= h_new;
      h_new <= {a_in, b_in};
      if (age < 2) age <= age + 1;
    end
  end

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int nstep_w, nerr_w, nstep_s, step_at_w;

  task automatic clear_counts();
    nstep_w = 0; nerr_w = 0; nstep_s = 0; step_at_w = -1;
  endtask

  // Drive an AB level and hold it for n cycles, tallying pulses seen.
  task automatic hold(input logic [1:0] v, input int n);
    a_in = v[1];
    b_in = v[0];
    repeat (n) begin
      @(negedge clk);
      cyc++;
      if (step_w) begin nstep_w++; step_at_w = cyc; end
      if (err_w) nerr_w++;
      if (step_s) nstep_s++;
    end
  endtask

  task automatic fwd_cycle();
    hold(2'b10, 3); hold(2'b11, 3); hold(2'b01, 3); hold(2'b00, 3);
  endtask

  task automatic do_reset(input logic [1:0] v);
    @(negedge clk);
    rst_n = 1'b0;
    clr = 1'b0;
    a_in = v[1];
    b_in = v[0];
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({pos_w, pos_s, pos_n} !== 20'h0) begin
      n_fail++; $display("FAIL reset_pos: got w=%0d s=%0d n=%0d, want 0", pos_w, pos_s, pos_n);
    end
    n_tests++;
    if ({step_arr, dir_arr, err_arr} !== 9'b0) begin
      n_fail++; $display("FAIL reset_flags: got step=%b dir=%b err=%b, want 0", step_arr, dir_arr, err_arr);
    end
    $display("[TB] reset: position=%0d step=%b dir=%b err=%b", pos_w, step_w, dir_w, err_w);
  endtask

  task automatic test_forward();
    int chg;
    do_reset(2'b00);
    hold(2'b00, 3);
    clear_counts();
    hold(2'b10, 3); hold(2'b11, 3); hold(2'b01, 3);
    chg = cyc;
    hold(2'b00, 4);
    n_tests++;
    if (nstep_w !== 1) begin n_fail++; $display("FAIL fwd_step_count: got %0d, want 1", nstep_w); end
    n_tests++;
    if (step_at_w - chg !== 2) begin n_fail++; $display("FAIL fwd_latency: got %0d cycles, want 2", step_at_w - chg); end
    n_tests++;
    if (pos_w !== 8'd1 || dir_w !== 1'b1) begin
      n_fail++; $display("FAIL fwd_pos_dir: got pos=%0d dir=%b, want pos=1 dir=1", pos_w, dir_w);
    end
    n_tests++;
    if (nerr_w !== 0) begin n_fail++; $display("FAIL fwd_no_err: got %0d err pulses, want 0", nerr_w); end
    $display("[TB] forward cycle: position=%0d dir=%b steps=%0d", pos_w, dir_w, nstep_w);
  endtask

  task automatic test_reverse();
    do_reset(2'b00);
    hold(2'b00, 3);
    clear_counts();
    hold(2'b01, 3); hold(2'b11, 3); hold(2'b10, 3); hold(2'b00, 4);
    n_tests++;
    if (pos_w !== 8'd255 || dir_w !== 1'b0 || nstep_w !== 1) begin
      n_fail++; $display("FAIL rev_wrap: got pos=%0d dir=%b steps=%0d, want 255 0 1", pos_w, dir_w, nstep_w);
    end
    n_tests++;
    if (pos_s !== 8'd0 || dir_s !== 1'b0 || nstep_s !== 0) begin
      n_fail++; $display("FAIL rev_sat: got pos=%0d dir=%b steps=%0d, want 0 0 0", pos_s, dir_s, nstep_s);
    end
    n_tests++;
    if (pos_n !== 4'd14) begin n_fail++; $display("FAIL rev_detent2: got pos=%0d, want 14", pos_n); end
    fwd_cycle();
    n_tests++;
    if (pos_w !== 8'd0 || dir_w !== 1'b1 || pos_s !== 8'd1) begin
      n_fail++; $display("FAIL fwd_wrap: got w=%0d dir=%b s=%0d, want 0 1 1", pos_w, dir_w, pos_s);
    end
    $display("[TB] reverse cycle: wrap position=%0d, saturating position=%0d", pos_w, pos_s);
  endtask

  task automatic test_err();
    do_reset(2'b00);
    hold(2'b00, 3);
    fwd_cycle();
    clear_counts();
    hold(2'b11, 4);
    n_tests++;
    if (nerr_w !== 1) begin n_fail++; $display("FAIL err_width: got %0d cycles, want 1", nerr_w); end
    n_tests++;
    if (pos_w !== 8'd1 || dir_w !== 1'b1 || nstep_w !== 0) begin
      n_fail++; $display("FAIL err_hold: got pos=%0d dir=%b steps=%0d, want 1 1 0", pos_w, dir_w, nstep_w);
    end
    hold(2'b01, 3); hold(2'b00, 3); hold(2'b10, 3);
    n_tests++;
    if (pos_w !== 8'd1) begin n_fail++; $display("FAIL err_sub_kept: got pos=%0d, want 1", pos_w); end
    hold(2'b11, 4);
    n_tests++;
    if (pos_w !== 8'd2 || nstep_w !== 1) begin
      n_fail++; $display("FAIL err_then_step: got pos=%0d steps=%0d, want 2 1", pos_w, nstep_w);
    end
    $display("[TB] double change: err pulses=%0d position=%0d", nerr_w, pos_w);
  endtask

  task automatic test_cancel();
    do_reset(2'b00);
    hold(2'b00, 3);
    clear_counts();
    hold(2'b10, 3); hold(2'b11, 3); hold(2'b10, 3); hold(2'b00, 3);
    n_tests++;
    if (nstep_w !== 0 || pos_w !== 8'd0) begin
      n_fail++; $display("FAIL cancel: got pos=%0d steps=%0d, want 0 0", pos_w, nstep_w);
    end
    hold(2'b10, 3); hold(2'b11, 3); hold(2'b01, 3);
    n_tests++;
    if (nstep_w !== 0) begin n_fail++; $display("FAIL cancel_sub_zero: got %0d steps, want 0", nstep_w); end
    hold(2'b00, 3);
    n_tests++;
    if (pos_w !== 8'd1 || nstep_w !== 1) begin
      n_fail++; $display("FAIL cancel_then_step: got pos=%0d steps=%0d, want 1 1", pos_w, nstep_w);
    end
    $display("[TB] cancelled quarters: position=%0d", pos_w);
  endtask

  task automatic test_clr();
    do_reset(2'b00);
    hold(2'b00, 3);
    repeat (5) fwd_cycle();
    n_tests++;
    if (pos_w !== 8'd5) begin n_fail++; $display("FAIL clr_setup: got pos=%0d, want 5", pos_w); end
    clear_counts();
    hold(2'b10, 3); hold(2'b11, 3); hold(2'b01, 3);
    hold(2'b00, 1);
    clr = 1'b1;
    hold(2'b00, 1);
    clr = 1'b0;
    hold(2'b00, 3);
    n_tests++;
    if (pos_w !== 8'd0 || nstep_w !== 0 || dir_w !== 1'b1) begin
      n_fail++; $display("FAIL clr_priority: got pos=%0d steps=%0d dir=%b, want 0 0 1", pos_w, nstep_w, dir_w);
    end
    fwd_cycle();
    n_tests++;
    if (pos_w !== 8'd1 || nstep_w !== 1) begin
      n_fail++; $display("FAIL clr_then_step: got pos=%0d steps=%0d, want 1 1", pos_w, nstep_w);
    end
    $display("[TB] clear over step: position=%0d", pos_w);
  endtask

  task automatic test_reset_live();
    do_reset(2'b11);
    clear_counts();
    hold(2'b11, 4);
    hold(2'b01, 3);
    n_tests++;
    if (nstep_w !== 0 || nerr_w !== 0 || pos_w !== 8'd0) begin
      n_fail++; $display("FAIL live_release: got steps=%0d errs=%0d pos=%0d, want 0 0 0", nstep_w, nerr_w, pos_w);
    end
    hold(2'b00, 3); hold(2'b10, 3);
    n_tests++;
    if (nstep_w !== 0) begin n_fail++; $display("FAIL live_early_step: got %0d steps, want 0", nstep_w); end
    hold(2'b11, 4);
    n_tests++;
    if (pos_w !== 8'd1 || nstep_w !== 1 || nerr_w !== 0) begin
      n_fail++; $display("FAIL live_sub_plus1: got pos=%0d steps=%0d errs=%0d, want 1 1 0", pos_w, nstep_w, nerr_w);
    end
    $display("[TB] reset with AB=11: position=%0d steps=%0d", pos_w, nstep_w);
  endtask

  task automatic test_midreset();
    do_reset(2'b00);
    hold(2'b00, 3);
    fwd_cycle();
    hold(2'b10, 3); hold(2'b11, 3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (pos_w !== 8'd0 || dir_w !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got pos=%0d dir=%b, want 0 0", pos_w, dir_w);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_counts();
    hold(2'b11, 3); hold(2'b01, 3); hold(2'b00, 3);
    n_tests++;
    if (nstep_w !== 0 || pos_w !== 8'd0) begin
      n_fail++; $display("FAIL partial_discard: got pos=%0d steps=%0d, want 0 0", pos_w, nstep_w);
    end
    hold(2'b10, 3); hold(2'b11, 4);
    n_tests++;
    if (pos_w !== 8'd1 || nstep_w !== 1) begin
      n_fail++; $display("FAIL after_midreset: got pos=%0d steps=%0d, want 1 1", pos_w, nstep_w);
    end
    $display("[TB] reset mid-rotation: position=%0d", pos_w);
  endtask

  task automatic test_random();
    int ph;
    int r;
    int bias;
    int fails_before;
    do_reset(2'b00);
    hold(2'b00, 3);
    ph = 0;
    bias = 1;
    fails_before = n_fail;
    for (int k = 0; k < 3000; k++) begin
      if (k % 250 == 0) bias = 4 - bias;
      r = int'($urandom_range(0, 99));
      if (r < 40)      ph = ph;
      else if (r < 75) ph = (ph + bias) % 4;
      else if (r < 93) ph = (ph + 4 - bias) % 4;
      else             ph = (ph + 2) % 4;
      {a_in, b_in} = ab_of(ph);
      clr = ($urandom_range(0, 99) < 2);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (int'(pos_arr[i]) !== m[i].pos) begin
          n_fail++; $display("FAIL rnd_pos inst%0d k=%0d: got %0d, want %0d", i, k, pos_arr[i], m[i].pos);
        end
        n_tests++;
        if (step_arr[i] !== m[i].step) begin
          n_fail++; $display("FAIL rnd_step inst%0d k=%0d: got %b, want %b", i, k, step_arr[i], m[i].step);
        end
        n_tests++;
        if (dir_arr[i] !== m[i].dir) begin
          n_fail++; $display("FAIL rnd_dir inst%0d k=%0d: got %b, want %b", i, k, dir_arr[i], m[i].dir);
        end
        n_tests++;
        if (err_arr[i] !== m[i].err) begin
          n_fail++; $display("FAIL rnd_err inst%0d k=%0d: got %b, want %b", i, k, err_arr[i], m[i].err);
        end
      end
    end
    clr = 1'b0;
    $display("[TB] random: 3000 cycles, %0d discrepancies", n_fail - fails_before);
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_err();
    test_cancel();
    test_clr();
    test_reset_live();
    test_midreset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8: position counter width in bits.
REQ-002 The module SHALL have parameter DETENT, default 4: quarter-steps per reported step; legal values 1, 2, 4.
REQ-003 The module SHALL have parameter WRAP, default 1: 1 = position wraps modulo 2^WIDTH, 0 = position saturates.
REQ-004 The module SHALL have parameter MAX_POS, default 2^WIDTH-1: upper saturation limit, used only when WRAP=0.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 a_in  input  1  debounced encoder channel A level, synchronous to clk.
REQ-008 b_in  input  1  debounced encoder channel B level, synchronous to clk.
REQ-009 clr  input  1  synchronous clear of position and sub-step accumulator.
REQ-010 position  output  WIDTH  current unsigned position.
REQ-011 step  output  1  one-cycle pulse, high in the cycle position changes.
REQ-012 dir  output  1  direction of the most recent step: 1 = forward, 0 = reverse.
REQ-013 err  output  1  one-cycle pulse on an illegal (double) AB transition.

Function
REQ-014 The module SHALL register {a_in,b_in} into ab_cur every cycle and hold the previous sample in ab_prev.
REQ-015 The FSM SHALL have two states: INIT and TRACK.
REQ-016 In INIT, the module SHALL load ab_prev from ab_cur, perform no decode, and enter TRACK on the next edge.
REQ-017 In TRACK, a forward quarter-step SHALL be any of the transitions 00->10, 10->11, 11->01 or 01->00, using {A,B} notation.
REQ-018 In TRACK, a reverse quarter-step SHALL be the inverse of any forward transition.
REQ-019 An unchanged AB SHALL produce no action.
REQ-020 A double change (00<->11 or 10<->01) SHALL pulse err for one cycle and leave position, sub-step accumulator and dir unchanged.
REQ-021 The module SHALL keep a signed sub-step accumulator sub in the range -(DETENT-1)..+(DETENT-1).
REQ-022 A forward quarter-step SHALL increment sub; if the result would equal +DETENT, sub SHALL become 0 and a forward step SHALL be issued.
REQ-023 A reverse quarter-step SHALL decrement sub; if the result would equal -DETENT, sub SHALL become 0 and a reverse step SHALL be issued.
REQ-024 On a forward step, position SHALL increment, step SHALL pulse, and dir SHALL be set to 1.
REQ-025 On a reverse step, position SHALL decrement, step SHALL pulse, and dir SHALL be cleared to 0.
REQ-026 With WRAP=1, position SHALL wrap 2^WIDTH-1 -> 0 going forward and 0 -> 2^WIDTH-1 going reverse.
REQ-027 With WRAP=0, a forward step at MAX_POS and a reverse step at 0 SHALL leave position unchanged, with step not pulsed and dir updated.
REQ-028 Latency: an AB change present before edge k SHALL produce step/err and the updated position after edge k+1 (2 cycles).
REQ-029 When clr=1, position and sub SHALL be 0 after the edge, and step SHALL be suppressed in that cycle.
REQ-030 clr SHALL have priority over a simultaneous step.
REQ-031 When clr=1, err and dir SHALL still update normally, and ab_prev SHALL still track ab_cur.
REQ-032 step, err and position SHALL be driven directly from registers, with no combinational path from inputs to outputs.

Reset
REQ-033 rst_n=0 SHALL asynchronously force position=0, step=0, dir=0, err=0, sub=0, ab_cur=00, ab_prev=00 and state=INIT.
REQ-034 After rst_n deasserts, the first decode SHALL occur only after INIT has captured the live AB level, so a non-00 AB at reset release produces no step or err.
REQ-035 Reset asserted mid-rotation SHALL discard the partial sub-step count.

Verification
REQ-036 DETENT=4, WRAP=1, position=0: drive one full forward cycle 00,10,11,01,00, each level held 3 cycles -> exactly one step pulse, position=1, dir=1, arriving 2 cycles after the 01->00 change.
REQ-037 DETENT=4, position=0, WRAP=1: one full reverse cycle -> position=255, dir=0; repeat with WRAP=0 -> position stays 0, no step pulse.
REQ-038 AB jumps 00->11 -> err pulses for exactly 1 cycle, and position, sub and dir are unchanged.
REQ-039 DETENT=4: two forward quarters then two reverse quarters -> no step pulse, sub returns to 0, position unchanged.
REQ-040 position=5: assert clr in the same cycle a forward step would issue -> position=0, no step pulse; next full forward cycle -> position=1.
REQ-041 Hold AB=11 through reset release, then drive 11->01 -> no step or err after release; sub=+1 after the transition.
